// File: rtl/seg_pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract unit that resolves SEG_W bits per stage and
// registers the inter-segment carry, with valid/ready handshakes on both sides.
module seg_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG_W;

    logic [STAGES-1:0] occ_s;
    logic [STAGES-1:0] ld_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        localparam int HI = LO + SEG_W;

        logic              src_v_s;
        logic [WIDTH-1:LO] src_a_s;
        logic [WIDTH-1:LO] src_b_s;
        logic              src_c_s;
        logic [SEG_W:0]    seg_s;
        logic [HI-1:0]     s_nx_s;
        logic              v_r;
        logic              c_r;
        logic [HI-1:0]     s_r;

        // A stage may load when it or any later stage is empty, or when the sink takes a beat.
        assign occ_s[k] = v_r;
        assign ld_s[k]  = out_ready | ~(&occ_s[STAGES-1:k]);

        if (k == 0) begin : g_src
            assign src_v_s = in_valid;
            assign src_a_s = a;
            assign src_b_s = sub ? ~b : b;
            assign src_c_s = sub ? 1'b1 : cin;
            assign s_nx_s  = seg_s[SEG_W-1:0];
        end else begin : g_src
            assign src_v_s = g_stage[k-1].v_r;
            assign src_a_s = g_stage[k-1].g_up.a_r;
            assign src_b_s = g_stage[k-1].g_up.b_r;
            assign src_c_s = g_stage[k-1].c_r;
            assign s_nx_s  = {seg_s[SEG_W-1:0], g_stage[k-1].s_r};
        end

        assign seg_s = {1'b0, src_a_s[HI-1:LO]} + {1'b0, src_b_s[HI-1:LO]}
                     + {{SEG_W{1'b0}}, src_c_s};

        // Valid flag, completed low segments and carry advance together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= {HI{1'b0}};
            end else if (ld_s[k]) begin
                v_r <= src_v_s;
                if (src_v_s) begin
                    c_r <= seg_s[SEG_W];
                    s_r <= s_nx_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_up
            logic [WIDTH-1:HI] a_r;
            logic [WIDTH-1:HI] b_r;

            // Only the not-yet-resolved upper operand segments travel onward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= {(WIDTH-HI){1'b0}};
                    b_r <= {(WIDTH-HI){1'b0}};
                end else if (ld_s[k] && src_v_s) begin
                    a_r <= src_a_s[WIDTH-1:HI];
                    b_r <= src_b_s[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic ovf_r;

            // Signed overflow uses the conditioned b, whose MSB is still visible here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (ld_s[k] && src_v_s) begin
                    ovf_r <= (src_a_s[WIDTH-1] == src_b_s[WIDTH-1])
                           & (seg_s[SEG_W-1] != src_a_s[WIDTH-1]);
                end
            end
        end
    end

    assign in_ready  = ld_s[0];
    assign out_valid = g_stage[STAGES-1].v_r;
    assign sum       = g_stage[STAGES-1].s_r;
    assign cout      = g_stage[STAGES-1].c_r;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Bench for seg_pipe_addsub: directed vectors and handshake sequences on the 16/4
// configuration, plus randomized streams on 8/1 and 32/8 against a reference model.
module tb_seg_pipe_addsub;
    logic clk;
    logic rst_n;
    logic rrst_n;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed DUT, WIDTH=16 SEG_W=4
    logic        div, dir, dov, dor, dci, dsb, dco, dof;
    logic [15:0] da, db, dsum;

    seg_pipe_addsub #(.WIDTH(16), .SEG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(div), .in_ready(dir),
        .a(da), .b(db), .cin(dci), .sub(dsb),
        .out_valid(dov), .out_ready(dor), .sum(dsum), .cout(dco), .ovf(dof)
    );

    // Randomized DUTs: 8/1 and 32/8
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int W  = (g == 0) ? 8 : 32;
        localparam int SW = (g == 0) ? 1 : 8;
        logic         iv, ir, ov, ordy, ci, sb, co, of;
        logic [W-1:0] ra, rb, sm;
        logic [W+1:0] expq[$];
        logic         fin;

        seg_pipe_addsub #(.WIDTH(W), .SEG_W(SW)) dut (
            .clk(clk), .rst_n(rrst_n), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .sub(sb),
            .out_valid(ov), .out_ready(ordy), .sum(sm), .cout(co), .ovf(of)
        );

        // Reference: unsigned arithmetic for cout/sum, signed range test for ovf.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic c, input logic s);
            longint unsigned ux, uy, ur;
            longint          sx, sy, sr, smax, smin;
            logic            carry;
            ux   = longint'(x);
            uy   = longint'(y);
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            smax = (longint'(1) << (W - 1)) - longint'(1);
            smin = -(longint'(1) << (W - 1));
            if (s) begin
                ur    = ux - uy;
                carry = (ux >= uy);
                sr    = sx - sy;
            end else begin
                ur    = ux + uy + longint'(c);
                carry = (ur >= (longint'(1) << W));
                sr    = sx + sy + longint'(c);
            end
            return {carry, ur[W-1:0], (sr > smax) || (sr < smin)};
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            case ($urandom_range(7))
                0:       v = {W{1'b1}};
                1:       v = {1'b1, {(W-1){1'b0}}};
                2:       v = {1'b0, {(W-1){1'b1}}};
                3:       v = {W{1'b0}};
                default: v = W'($urandom);
            endcase
            return v;
        endfunction

        initial begin
            int           sent, got;
            logic         hold, stalled;
            logic [W+1:0] last, e;
            fin = 1'b0; iv = 1'b0; ordy = 1'b0; ra = '0; rb = '0; ci = 1'b0; sb = 1'b0;
            sent = 0; got = 0; hold = 1'b0; stalled = 1'b0; last = '0;
            wait (rrst_n === 1'b1);
            for (int cyc = 0; cyc < 30000 && got < 2000; cyc++) begin
                @(posedge clk); #1;
                if (!hold) begin
                    iv = (sent < 2000) && ($urandom_range(3) != 0);
                    ra = pick(); rb = pick();
                    ci = 1'($urandom); sb = 1'($urandom);
                end
                ordy = ($urandom_range(3) != 0);
                @(negedge clk);
                if (stalled) chk("rand_hold", {ov, co, sm, of}, {1'b1, last});
                if (iv && ir) begin
                    expq.push_back(model(ra, rb, ci, sb));
                    sent++;
                    hold = 1'b0;
                end else begin
                    hold = iv;
                end
                if (ov && ordy) begin
                    if (expq.size() == 0) begin
                        chk("rand_extra_result", 64'd1, 64'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("rand_result", {co, sm, of}, e);
                    end
                    got++;
                end
                stalled = ov && !ordy;
                last    = {co, sm, of};
            end
            chk("rand_count", 64'(got), 64'd2000);
            @(posedge clk); #1;
            iv = 1'b0;
            fin = 1'b1;
        end
    end

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        co, of;
    } vec_t;
    vec_t vt[10];

    task automatic apply(input vec_t v);
        int lat;
        @(posedge clk); #1;
        da = v.a; db = v.b; dci = v.cin; dsb = v.sub; div = 1'b1; dor = 1'b1;
        chk("in_ready_idle", dir, 1'b1);
        for (lat = 1; lat <= 12; lat++) begin
            @(posedge clk); #1;
            if (lat == 1) div = 1'b0;
            if (dov) break;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("result", {dco, dsum, dof}, {v.co, v.s, v.of});
    endtask

    initial begin
        int cur;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; rrst_n = 1'b0;
        div = 1'b0; dor = 1'b0; da = 16'h0000; db = 16'h0000; dci = 1'b0; dsb = 1'b0;
        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[6] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[8] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
        vt[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        #22;
        rst_n = 1'b1; rrst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", dov, 1'b0);
        chk("reset_in_ready", dir, 1'b1);
        chk("reset_outputs", {dco, dsum, dof}, 18'h0);

        for (int i = 0; i < 10; i++) apply(vt[i]);

        // Backpressure: 4 of 6 beats accepted while the sink is stalled.
        @(posedge clk); #1;
        dor = 1'b0; cur = 0;
        for (int c = 0; c < 8; c++) begin
            div = (cur < 6); da = 16'(cur * 257 + 1); db = 16'h0010; dci = 1'b0; dsb = 1'b0;
            @(negedge clk);
            if (c >= 4) begin
                chk("bp_in_ready", dir, 1'b0);
                chk("bp_out_valid", dov, 1'b1);
                chk("bp_hold", {dco, dsum, dof}, {1'b0, 16'h0011, 1'b0});
            end
            if (div && dir) cur++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(cur), 64'd4);
        dor = 1'b1;
        for (int c = 0; c < 6; c++) begin
            div = (cur < 6); da = 16'(cur * 257 + 1);
            @(negedge clk);
            chk("drain_valid", dov, 1'b1);
            chk("drain_order", dsum, 16'(c * 257 + 17));
            if (div && dir) cur++;
            @(posedge clk); #1;
        end
        div = 1'b0;
        chk("drain_accepted", 64'(cur), 64'd6);

        // Asynchronous reset with a stalled result at the output.
        @(posedge clk); #1;
        dor = 1'b0; da = 16'h00FF; db = 16'h0001; dci = 1'b0; dsb = 1'b0; div = 1'b1;
        @(posedge clk); #1;
        div = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_valid", dov, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", dov, 1'b0);
        chk("rst_async_outputs", {dco, dsum, dof}, 18'h0);
        #1 rst_n = 1'b1;
        dor = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rst_no_stale", dov, 1'b0);
        end
        apply(vt[0]);

        for (int i = 0; i < 60000 && !(g_rand[0].fin && g_rand[1].fin); i++) @(posedge clk);
        chk("rand_finished", {g_rand[0].fin, g_rand[1].fin}, 2'b11);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
